register_file: RTL and testbench

// Architectural register file with rename tags for the RV32I out-of-order core. Sits between the

---
 rtl/register_file.sv | 215 +++++++++++++++++++++
 tb/tb_register_file.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// -----------------------------------------------------------------------------
// register_file
//
// Architectural register file with rename tags for the RV32I out-of-order core.
// It sits between the instruction unit (issue/rename) and the reorder buffer
// (commit). It holds 32 x 32-bit registers, and each register also has a dirty
// bit and a ROB tag. While a register is dirty, its newest value is still in
// flight. The tag names the ROB entry that will produce that value.
//
// Source operands are resolved combinationally, with zero latency. The
// priority order is:
//   1. committed value, when the register is clean
//   2. same-cycle commit bypass, when the commit carries the awaited tag
//   3. value forwarded by the ROB for the tag
// When none of these apply, the operand is not ready. The issuer must then
// wait on the tag.
//
// Ports
//   clockIn, resetIn             clock; asynchronous active-low reset
//   readyIn                      global enable; no state changes while low
//   clear                        misprediction flush: drops every dirty bit
//   regUpdate*                   commit strobe, destination, value and ROB id
//   rename*                      rename strobe, destination and ROB id
//   rs1Addr, rs2Addr             sources of the instruction being issued
//   rs1Dep, rs2Dep               tags sent to the ROB for lookup
//   robRs1*, robRs2*             ROB lookup results for those tags
//   rs1Ready/Value/Tag, rs2...   resolved operands
// -----------------------------------------------------------------------------
module register_file #(
  parameter int ROB_WIDTH = 4
) (
  input  logic                 clockIn,
  input  logic                 resetIn,
  input  logic                 readyIn,
  input  logic                 clear,
  input  logic                 regUpdateValid,
  input  logic [4:0]           regUpdateDest,
  input  logic [31:0]          regValue,
  input  logic [ROB_WIDTH-1:0] regUpdateRobId,
  input  logic                 renameValid,
  input  logic [4:0]           renameDest,
  input  logic [ROB_WIDTH-1:0] renameRobId,
  input  logic [4:0]           rs1Addr,
  input  logic [4:0]           rs2Addr,
  output logic [ROB_WIDTH-1:0] rs1Dep,
  output logic [ROB_WIDTH-1:0] rs2Dep,
  input  logic                 robRs1Ready,
  input  logic [31:0]          robRs1Value,
  input  logic                 robRs2Ready,
  input  logic [31:0]          robRs2Value,
  output logic                 rs1Ready,
  output logic [31:0]          rs1Value,
  output logic [ROB_WIDTH-1:0] rs1Tag,
  output logic                 rs2Ready,
  output logic [31:0]          rs2Value,
  output logic [ROB_WIDTH-1:0] rs2Tag
);

  localparam int NUM_REGS = 32;

  typedef logic [ROB_WIDTH-1:0] tag_t;

  // A resolved source operand, as seen by the issue stage.
  typedef struct packed {
    logic        ready;
    logic [31:0] value;
  } operand_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [31:0]         reg_q   [NUM_REGS];
  logic [31:0]         reg_d   [NUM_REGS];
  logic [NUM_REGS-1:0] dirty_q;
  logic [NUM_REGS-1:0] dirty_d;
  tag_t                tag_q   [NUM_REGS];
  tag_t                tag_d   [NUM_REGS];

  // x0 is hardwired, so commits and renames that target it are dropped here.
  // This keeps x0 permanently clean, zero, and tagged 0.
  logic commit_en;
  logic rename_en;

  assign commit_en = regUpdateValid && (regUpdateDest != 5'd0);
  assign rename_en = renameValid && (renameDest != 5'd0) && !clear;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a hold default before any branch, so no path
    // leaves it unassigned and no latch is inferred.
    reg_d   = reg_q;
    dirty_d = dirty_q;
    tag_d   = tag_q;

    if (readyIn) begin
      // A commit always writes the value. It clears the dirty bit only if it
      // is the rename the register is waiting on. If a younger rename has
      // retagged the register, that rename keeps it dirty.
      if (commit_en) begin
        reg_d[regUpdateDest] = regValue;
        if (tag_q[regUpdateDest] == regUpdateRobId) begin
          dirty_d[regUpdateDest] = 1'b0;
        end
      end

      // A flush drops all rename state. Stale tags are left in place because
      // they are ignored while the register is clean. Otherwise, a rename
      // issued in the same cycle as a commit to the same register overrides
      // the commit's dirty-bit clear, because it is ordered after the commit.
      if (clear) begin
        dirty_d = '0;
      end else if (rename_en) begin
        dirty_d[renameDest] = 1'b1;
        tag_d[renameDest]   = renameRobId;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clockIn or negedge resetIn) begin
    if (!resetIn) begin
      // NOTE: the register array is reset as ordinary flops. A reset must leave
      // every register reading zero and clean, which a RAM macro cannot provide.
      for (int i = 0; i < NUM_REGS; i++) begin
        reg_q[i] <= '0;
        tag_q[i] <= '0;
      end
      dirty_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // flop samples pre-edge values regardless of statement order.
      for (int i = 0; i < NUM_REGS; i++) begin
        reg_q[i] <= reg_d[i];
        tag_q[i] <= tag_d[i];
      end
      dirty_q <= dirty_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Operand resolution
  // ---------------------------------------------------------------------------
  // Reads see state from before this cycle's rename. An instruction therefore
  // never waits on its own destination tag.
  function automatic operand_t resolve(
    input logic [4:0]  addr,
    input logic        dirty,
    input logic [31:0] committed,
    input tag_t        tag,
    input logic        upd_valid,
    input logic [4:0]  upd_dest,
    input tag_t        upd_rob_id,
    input logic [31:0] upd_value,
    input logic        rob_ready,
    input logic [31:0] rob_value
  );
    operand_t op;
    op.ready = 1'b0;
    op.value = '0;
    if (addr == 5'd0) begin
      op.ready = 1'b1;
    end else if (!dirty) begin
      op.ready = 1'b1;
      op.value = committed;
    end else if (upd_valid && (upd_dest == addr) && (upd_rob_id == tag)) begin
      // The awaited producer is committing right now. Its value is not yet in
      // the ROB lookup path and not yet in the array, so it is taken from the
      // commit bus.
      op.ready = 1'b1;
      op.value = upd_value;
    end else if (rob_ready) begin
      op.ready = 1'b1;
      op.value = rob_value;
    end
    return op;
  endfunction

  tag_t     rs1_tag;
  tag_t     rs2_tag;
  operand_t rs1_op;
  operand_t rs2_op;

  always_comb begin
    rs1_tag = tag_q[rs1Addr];
    rs2_tag = tag_q[rs2Addr];
    rs1_op  = resolve(rs1Addr, dirty_q[rs1Addr], reg_q[rs1Addr], rs1_tag,
                      regUpdateValid, regUpdateDest, regUpdateRobId, regValue,
                      robRs1Ready, robRs1Value);
    rs2_op  = resolve(rs2Addr, dirty_q[rs2Addr], reg_q[rs2Addr], rs2_tag,
                      regUpdateValid, regUpdateDest, regUpdateRobId, regValue,
                      robRs2Ready, robRs2Value);
  end

  assign rs1Dep   = rs1_tag;
  assign rs2Dep   = rs2_tag;
  assign rs1Tag   = rs1_tag;
  assign rs2Tag   = rs2_tag;
  assign rs1Ready = rs1_op.ready;
  assign rs1Value = rs1_op.value;
  assign rs2Ready = rs2_op.ready;
  assign rs2Value = rs2_op.value;

  // ---------------------------------------------------------------------------
  // Invariants
  // ---------------------------------------------------------------------------
  x0_stays_clean_zero : assert property (
    @(posedge clockIn) disable iff (!resetIn)
    !dirty_q[0] && (reg_q[0] == 32'd0) && (tag_q[0] == '0)
  );

endmodule

// File: tb/tb_register_file.sv
// -----------------------------------------------------------------------------
// tb_register_file
//
// Bench for register_file. Each vector record holds one cycle of inputs plus
// the operand outputs expected combinationally during that cycle. Those inputs
// take effect on the following rising edge. Expected records are queued when a
// record is driven and popped when the outputs are sampled. A hand-written
// sequence covers the asynchronous reset asserted mid-cycle.
// -----------------------------------------------------------------------------
module tb_register_file;

  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ready_in;
  logic          clear;
  logic          upd_valid;
  logic [4:0]    upd_dest;
  logic [31:0]   upd_value;
  logic [RW-1:0] upd_rob;
  logic          ren_valid;
  logic [4:0]    ren_dest;
  logic [RW-1:0] ren_rob;
  logic [4:0]    rs1_addr;
  logic [4:0]    rs2_addr;
  logic [RW-1:0] rs1_dep;
  logic [RW-1:0] rs2_dep;
  logic          rob1_ready;
  logic [31:0]   rob1_value;
  logic          rob2_ready;
  logic [31:0]   rob2_value;
  logic          rs1_ready;
  logic [31:0]   rs1_value;
  logic [RW-1:0] rs1_tag;
  logic          rs2_ready;
  logic [31:0]   rs2_value;
  logic [RW-1:0] rs2_tag;

  register_file #(.ROB_WIDTH(RW)) dut (
    .clockIn        (clk),
    .resetIn        (rst_n),
    .readyIn        (ready_in),
    .clear          (clear),
    .regUpdateValid (upd_valid),
    .regUpdateDest  (upd_dest),
    .regValue       (upd_value),
    .regUpdateRobId (upd_rob),
    .renameValid    (ren_valid),
    .renameDest     (ren_dest),
    .renameRobId    (ren_rob),
    .rs1Addr        (rs1_addr),
    .rs2Addr        (rs2_addr),
    .rs1Dep         (rs1_dep),
    .rs2Dep         (rs2_dep),
    .robRs1Ready    (rob1_ready),
    .robRs1Value    (rob1_value),
    .robRs2Ready    (rob2_ready),
    .robRs2Value    (rob2_value),
    .rs1Ready       (rs1_ready),
    .rs1Value       (rs1_value),
    .rs1Tag         (rs1_tag),
    .rs2Ready       (rs2_ready),
    .rs2Value       (rs2_value),
    .rs2Tag         (rs2_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rdy;
    logic          clr;
    logic          uv;
    logic [4:0]    ud;
    logic [31:0]   uval;
    logic [RW-1:0] urob;
    logic          rv;
    logic [4:0]    rd;
    logic [RW-1:0] rrob;
    logic [4:0]    a1;
    logic [4:0]    a2;
    logic          r1r;
    logic [31:0]   r1v;
    logic          r2r;
    logic [31:0]   r2v;
    logic          e1r;
    logic [31:0]   e1v;
    logic [RW-1:0] e1t;
    logic          e2r;
    logic [31:0]   e2v;
    logic [RW-1:0] e2t;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(
    input logic rdy, input logic clr,
    input logic uv, input logic [4:0] ud, input logic [31:0] uval, input logic [RW-1:0] urob,
    input logic rv, input logic [4:0] rd, input logic [RW-1:0] rrob,
    input logic [4:0] a1, input logic [4:0] a2,
    input logic r1r, input logic [31:0] r1v, input logic r2r, input logic [31:0] r2v,
    input logic e1r, input logic [31:0] e1v, input logic [RW-1:0] e1t,
    input logic e2r, input logic [31:0] e2v, input logic [RW-1:0] e2t);
    vec_t v;
    v.rdy = rdy;  v.clr = clr;
    v.uv  = uv;   v.ud  = ud;   v.uval = uval; v.urob = urob;
    v.rv  = rv;   v.rd  = rd;   v.rrob = rrob;
    v.a1  = a1;   v.a2  = a2;
    v.r1r = r1r;  v.r1v = r1v;  v.r2r  = r2r;  v.r2v  = r2v;
    v.e1r = e1r;  v.e1v = e1v;  v.e1t  = e1t;
    v.e2r = e2r;  v.e2v = e2v;  v.e2t  = e2t;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    ready_in   = v.rdy;  clear     = v.clr;
    upd_valid  = v.uv;   upd_dest  = v.ud;  upd_value = v.uval; upd_rob = v.urob;
    ren_valid  = v.rv;   ren_dest  = v.rd;  ren_rob   = v.rrob;
    rs1_addr   = v.a1;   rs2_addr  = v.a2;
    rob1_ready = v.r1r;  rob1_value = v.r1v;
    rob2_ready = v.r2r;  rob2_value = v.r2v;
  endtask

  task automatic compare_outputs(input int id);
    vec_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL vec%0d scoreboard: got empty queue expected an entry", id);
      return;
    end
    e = exp_q.pop_front();
    check($sformatf("vec%0d rs1Ready", id), 32'(rs1_ready), 32'(e.e1r));
    check($sformatf("vec%0d rs1Value", id), rs1_value,      e.e1v);
    check($sformatf("vec%0d rs1Tag",   id), 32'(rs1_tag),   32'(e.e1t));
    check($sformatf("vec%0d rs1Dep",   id), 32'(rs1_dep),   32'(e.e1t));
    check($sformatf("vec%0d rs2Ready", id), 32'(rs2_ready), 32'(e.e2r));
    check($sformatf("vec%0d rs2Value", id), rs2_value,      e.e2v);
    check($sformatf("vec%0d rs2Tag",   id), 32'(rs2_tag),   32'(e.e2t));
    check($sformatf("vec%0d rs2Dep",   id), 32'(rs2_dep),   32'(e.e2t));
  endtask

  // Drive just after a rising edge and sample on the falling edge. The record
  // takes effect on the next rising edge.
  task automatic run_vec(input vec_t v, input int id);
    @(posedge clk);
    #1;
    drive(v);
    exp_q.push_back(v);
    @(negedge clk);
    compare_outputs(id);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    vec_t idle;
    vec_t v;

    //        rdy clr  uv ud  uval         urob  rv rd rrob  a1 a2  r1r r1v      r2r r2v     e1r e1v       e1t  e2r e2v       e2t
    // Reset state.
    vecs.push_back(mk(1,0, 0,0,0,0,           0,0,0,     5,0,   0,0,       0,0,       1,0,0,            1,0,0));
    // Rename x5 -> tag 3. The read sees the pre-rename state.
    vecs.push_back(mk(1,0, 0,0,0,0,           1,5,3,     5,0,   0,0,       0,0,       1,0,0,            1,0,0));
    vecs.push_back(mk(1,0, 0,0,0,0,           0,0,0,     5,0,   0,'hDEAD,  0,0,       0,0,3,            1,0,0));
    vecs.push_back(mk(1,0, 0,0,0,0,           0,0,0,     5,0,   1,'h1234,  0,0,       1,'h1234,3,       1,0,0));
    // Younger rename x5 -> 7, then the older commit with tag 3 arrives.
    vecs.push_back(mk(1,0, 0,0,0,0,           1,5,7,     5,0,   0,0,       0,0,       0,0,3,            1,0,0));
    vecs.push_back(mk(1,0, 1,5,'hAA,3,        0,0,0,     5,0,   0,0,       0,0,       0,0,7,            1,0,0));
    vecs.push_back(mk(1,0, 0,0,0,0,           0,0,0,     5,5,   0,0,       1,'h77,    0,0,7,            1,'h77,7));
    // A matching commit bypasses, with priority over the ROB forward.
    vecs.push_back(mk(1,0, 1,5,'hBB,7,        0,0,0,     5,0,   1,'hCC,    0,0,       1,'hBB,7,         1,0,0));
    vecs.push_back(mk(1,0, 0,0,0,0,           0,0,0,     5,0,   1,'hCC,    0,0,       1,'hBB,7,         1,0,0));
    // Rename x1..x4, then clear with a rename of x6 and a commit to x2.
    vecs.push_back(mk(1,0, 0,0,0,0,           1,1,1,     1,2,   0,0,       0,0,       1,0,0,            1,0,0));
    vecs.push_back(mk(1,0, 0,0,0,0,           1,2,2,     1,2,   0,0,       0,0,       0,0,1,            1,0,0));
    vecs.push_back(mk(1,0, 0,0,0,0,           1,3,4,     1,2,   0,0,       0,0,       0,0,1,            0,0,2));
    vecs.push_back(mk(1,0, 0,0,0,0,           1,4,5,     3,4,   0,0,       0,0,       0,0,4,            1,0,0));
    vecs.push_back(mk(1,1, 1,2,'h55,2,        1,6,6,     2,4,   0,0,       0,0,       1,'h55,2,         0,0,5));
    vecs.push_back(mk(1,0, 0,0,0,0,           0,0,0,     6,2,   0,0,       0,0,       1,0,0,            1,'h55,2));
    vecs.push_back(mk(1,0, 0,0,0,0,           0,0,0,     1,4,   1,'h99,    0,0,       1,0,1,            1,0,5));
    // Commit and rename to x0 are ignored.
    vecs.push_back(mk(1,0, 1,0,'hFFFFFFFF,0,  1,0,9,     0,0,   0,0,       0,0,       1,0,0,            1,0,0));
    // With readyIn low, the rename of x8 and the commit to x3 are ignored.
    vecs.push_back(mk(0,0, 1,3,'h33,4,        1,8,8,     0,3,   1,'h5,     0,0,       1,0,0,            1,0,4));
    vecs.push_back(mk(1,0, 0,0,0,0,           0,0,0,     8,3,   0,0,       0,0,       1,0,0,            1,0,4));
    // Tag 0 is a legal rename tag.
    vecs.push_back(mk(1,0, 0,0,0,0,           1,10,0,    10,0,  0,0,       0,0,       1,0,0,            1,0,0));
    vecs.push_back(mk(1,0, 0,0,0,0,           0,0,0,     10,0,  0,0,       0,0,       0,0,0,            1,0,0));
    vecs.push_back(mk(1,0, 1,10,'h1010,0,     0,0,0,     10,10, 0,0,       1,'hEE,    1,'h1010,0,       1,'h1010,0));
    vecs.push_back(mk(1,0, 0,0,0,0,           0,0,0,     10,0,  0,0,       0,0,       1,'h1010,0,       1,0,0));
    // Top tag, then commit plus rename of the same register in one cycle.
    vecs.push_back(mk(1,0, 0,0,0,0,           1,11,15,   11,0,  0,0,       0,0,       1,0,0,            1,0,0));
    vecs.push_back(mk(1,0, 1,11,'hF0,15,      1,11,14,   11,0,  0,0,       0,0,       1,'hF0,15,        1,0,0));
    vecs.push_back(mk(1,0, 0,0,0,0,           0,0,0,     11,11, 0,0,       1,'hAB,    0,0,14,           1,'hAB,14));
    // readyIn low suppresses both clear and the commit. The bypass still resolves.
    vecs.push_back(mk(1,0, 0,0,0,0,           1,9,9,     9,0,   0,0,       0,0,       1,0,0,            1,0,0));
    vecs.push_back(mk(0,1, 1,9,'h99,9,        0,0,0,     9,11,  0,0,       0,0,       1,'h99,9,         0,0,14));
    vecs.push_back(mk(1,0, 0,0,0,0,           0,0,0,     9,11,  0,0,       0,0,       0,0,9,            0,0,14));
    // A commit with a stale tag does not bypass and leaves x9 dirty.
    vecs.push_back(mk(1,0, 1,9,'h98,8,        0,0,0,     9,0,   1,'h42,    0,0,       1,'h42,9,         1,0,0));
    vecs.push_back(mk(1,0, 0,0,0,0,           0,0,0,     9,0,   0,0,       0,0,       0,0,9,            1,0,0));

    idle = mk(1,0, 0,0,0,0, 0,0,0, 0,0, 0,0, 0,0, 1,0,0, 1,0,0);
    drive(idle);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Reset asserted mid-cycle. Outputs change at once, without a clock edge.
    @(posedge clk);
    #1;
    v = mk(1,0, 0,0,0,0, 0,0,0, 5,9, 0,0, 0,0, 1,'hBB,7, 0,0,9);
    drive(v);
    exp_q.push_back(v);
    #2;
    compare_outputs(100);
    #1;
    rst_n = 1'b0;
    v = mk(1,0, 0,0,0,0, 1,12,3, 5,9, 0,0, 0,0, 1,0,0, 1,0,0);
    drive(v);
    exp_q.push_back(v);
    #1;
    compare_outputs(101);
    // Hold reset across an edge with a rename pending. Nothing may stick.
    @(posedge clk);
    #1;
    exp_q.push_back(v);
    compare_outputs(102);
    @(negedge clk);
    ren_valid = 1'b0;
    rst_n     = 1'b1;
    run_vec(mk(1,0, 0,0,0,0, 0,0,0, 12,9,  0,0, 0,0, 1,0,0, 1,0,0), 103);
    run_vec(mk(1,0, 0,0,0,0, 0,0,0, 5,11,  0,0, 0,0, 1,0,0, 1,0,0), 104);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
